// File: rtl/vga_game_pkg.sv
// rtl/vga_game_pkg.sv - timing constants, game states and colours for the ball/paddle game
package vga_game_pkg;
  localparam logic [10:0] H_TOTAL      = 11'd800;
  localparam logic [10:0] V_TOTAL      = 11'd525;
  localparam logic [10:0] H_ACT_START  = 11'd144;
  localparam logic [10:0] H_ACT_END    = 11'd784;
  localparam logic [10:0] V_ACT_START  = 11'd35;
  localparam logic [10:0] V_ACT_END    = 11'd515;
  localparam logic [10:0] FRAME_TICK_Y = 11'd515;

  localparam logic [10:0] PADDLE_X0 = 11'd432;
  localparam logic [10:0] BALL_X0   = 11'd460;
  localparam logic [10:0] BALL_Y0   = 11'd270;

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} game_state_t;

  localparam logic [11:0] WHITE = 12'hfff;
  localparam logic [11:0] GREEN = 12'h0f0;
  localparam logic [11:0] RED   = 12'hf00;
  localparam logic [11:0] BLACK = 12'h000;
endpackage

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - paddle x register, moved once per enabled frame tick and clamped to the active area
module paddle_ctrl
  import vga_game_pkg::*;
#(
  parameter int PADDLE_W    = 64,
  parameter int PADDLE_STEP = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        btn_l,
  input  logic        btn_r,
  output logic [10:0] px
);
  localparam logic [10:0] STEP   = 11'(PADDLE_STEP);
  localparam logic [10:0] PX_MAX = H_ACT_END - 11'(PADDLE_W);

  always_ff @(posedge clk) begin
    if (clr) begin
      px <= PADDLE_X0;
    end else if (en) begin
      if (btn_l && !btn_r)
        px <= (px < H_ACT_START + STEP) ? H_ACT_START : px - STEP;
      else if (btn_r && !btn_l)
        px <= (px + STEP > PX_MAX) ? PX_MAX : px + STEP;
    end
  end
endmodule

// File: rtl/ball_paddle_renderer.sv
// rtl/ball_paddle_renderer.sv - ball-and-paddle game state and registered pixel colour for the VGA timing block
module ball_paddle_renderer
  import vga_game_pkg::*;
#(
  parameter int BALL_SIZE    = 8,
  parameter int BALL_STEP    = 2,
  parameter int PADDLE_W     = 64,
  parameter int PADDLE_H     = 8,
  parameter int PADDLE_Y     = 490,
  parameter int PADDLE_STEP  = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_LIMIT   = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] xsync,
  input  logic [9:0] ysync,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_start,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic [7:0] score,
  output logic [1:0] misses,
  output logic       game_over
);
  localparam logic [10:0] BSIZE      = 11'(BALL_SIZE);
  localparam logic [10:0] BSTEP      = 11'(BALL_STEP);
  localparam logic [10:0] PW         = 11'(PADDLE_W);
  localparam logic [10:0] PH         = 11'(PADDLE_H);
  localparam logic [10:0] PY         = 11'(PADDLE_Y);
  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [1:0]  MISS_LAST  = 2'(MISS_LIMIT - 1);

  game_state_t state;
  logic [10:0] x, y, px, bx, by, nx, ny;
  logic        dx, dy, ndx, ndy;   // 1 = moving towards larger coordinates
  logic [7:0]  serve_cnt;
  logic        start_q, start_rise, frame_tick, hit, lost;
  logic        ball_on, paddle_on, active;
  logic [11:0] pix, rgb;

  assign x          = {1'b0, xsync};
  assign y          = {1'b0, ysync};
  assign frame_tick = (x == 11'd0) && (y == FRAME_TICK_Y);
  assign start_rise = btn_start && !start_q;

  paddle_ctrl #(.PADDLE_W(PADDLE_W), .PADDLE_STEP(PADDLE_STEP)) u_paddle (
    .clk   (clk),
    .clr   (clr),
    .en    (frame_tick && (state != OVER)),
    .btn_l (btn_l),
    .btn_r (btn_r),
    .px    (px)
  );

  always_comb begin
    nx  = dx ? bx + BSTEP : bx - BSTEP;
    ny  = dy ? by + BSTEP : by - BSTEP;
    ndx = dx;
    ndy = dy;
    if (nx < H_ACT_START) begin
      nx  = H_ACT_START;
      ndx = !dx;
    end else if (nx + BSIZE > H_ACT_END) begin
      nx  = H_ACT_END - BSIZE;
      ndx = !dx;
    end
    if (ny < V_ACT_START) begin
      ny  = V_ACT_START;
      ndy = !dy;
    end
    // paddle contact is judged against the paddle position before this tick's move
    hit  = dy && (ny + BSIZE >= PY) && (by + BSIZE < PY + PH) &&
           (nx + BSIZE > px) && (nx < px + PW);
    lost = !hit && (ny + BSIZE > V_ACT_END);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      score     <= 8'd0;
      misses    <= 2'd0;
      game_over <= 1'b0;
      bx        <= BALL_X0;
      by        <= BALL_Y0;
      dx        <= 1'b1;
      dy        <= 1'b0;
      serve_cnt <= 8'd0;
      start_q   <= 1'b0;
    end else begin
      start_q <= btn_start;
      case (state)
        IDLE, OVER: begin
          if (start_rise) begin
            state     <= SERVE;
            score     <= 8'd0;
            misses    <= 2'd0;
            game_over <= 1'b0;
            bx        <= BALL_X0;
            by        <= BALL_Y0;
            dx        <= 1'b1;
            dy        <= 1'b0;
            serve_cnt <= 8'd0;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (serve_cnt == SERVE_LAST) state <= PLAY;
            else serve_cnt <= serve_cnt + 8'd1;
          end
        end
        PLAY: begin
          if (frame_tick) begin
            if (hit) begin
              bx <= nx;
              by <= PY - BSIZE;
              dx <= ndx;
              dy <= 1'b0;
              if (score != 8'hff) score <= score + 8'd1;
            end else if (lost) begin
              misses <= misses + 2'd1;
              if (misses == MISS_LAST) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state     <= SERVE;
                bx        <= BALL_X0;
                by        <= BALL_Y0;
                dx        <= 1'b1;
                dy        <= 1'b0;
                serve_cnt <= 8'd0;
              end
            end else begin
              bx <= nx;
              by <= ny;
              dx <= ndx;
              dy <= ndy;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    active    = (x >= H_ACT_START) && (x < H_ACT_END) && (y >= V_ACT_START) && (y < V_ACT_END);
    ball_on   = ((state == SERVE) || (state == PLAY)) &&
                (x >= bx) && (x < bx + BSIZE) && (y >= by) && (y < by + BSIZE);
    paddle_on = (x >= px) && (x < px + PW) && (y >= PY) && (y < PY + PH);
    pix       = BLACK;
    if (active) begin
      if (ball_on)        pix = WHITE;
      else if (paddle_on) pix = (state == OVER) ? RED : GREEN;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) rgb <= BLACK;
    else     rgb <= pix;
  end

  assign r = rgb[11:8];
  assign g = rgb[7:4];
  assign b = rgb[3:0];
endmodule
